// File: rtl/nchan_seq_mux_pkg.sv
// Shared types and helpers for the N-channel registered mux and its pointer logic.
// Mode encoding, per-edge action decode and index-width helper live here.
package nchan_seq_mux_pkg;

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_SCAN   = 1'b1
   } mode_e;

   // What the output/scan registers do on the coming edge.
   typedef enum logic [2:0] {
      ACT_MANUAL,
      ACT_RESTART,
      ACT_COUNT,
      ACT_IDLE,
      ACT_SKIP,
      ACT_STALL,
      ACT_CAPTURE
   } act_e;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nchan_seq_mux_rr_next_sel.sv
// Combinational round-robin helper: next enabled channel strictly after ptr, with wrap.
// Returns ptr itself when it is the only enabled channel; any_en flags a non-empty mask.
module rr_next_sel
   import nchan_seq_mux_pkg::*;
#(
   parameter  int N  = 4,
   localparam int SW = idx_width(N)
) (
   input  logic [N-1:0]  en,
   input  logic [SW-1:0] ptr,
   output logic [SW-1:0] nxt,
   output logic          any_en
);

   // Walk offsets from farthest to nearest so the nearest enabled channel wins.
   always_comb begin
      // NOTE: default assignment first so no path leaves nxt unassigned (no latch).
      nxt = ptr;
      for (int i = N; i >= 1; i--) begin
         if (en[(int'(ptr) + i) % N]) nxt = SW'((int'(ptr) + i) % N);
      end
   end

   assign any_en = |en;

endmodule

// File: rtl/nchan_seq_mux.sv
// N-channel W-bit registered mux with VALID/READY output, enable mask and auto-scan.
// Manual mode captures d_in[s]; scan mode visits enabled channels every DWELL cycles.
module nchan_seq_mux
   import nchan_seq_mux_pkg::*;
#(
   parameter  int N     = 4,
   parameter  int W     = 4,
   parameter  int DWELL = 4,
   localparam int SW    = idx_width(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N*W-1:0]  d_in,
   input  logic [SW-1:0]   s,
   input  logic            mode,
   input  logic [N-1:0]    en,
   input  logic            ready,
   output logic [W-1:0]    y,
   output logic [SW-1:0]   ch,
   output logic            valid
);

   localparam int            CW       = idx_width(DWELL);
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

   logic [SW-1:0] ptr, ptr_next;
   logic [CW-1:0] cnt;
   logic          mode_q;
   logic          any_en, free, at_cap, mode_chg, sel_ok;
   logic [W-1:0]  d_sel, d_ptr;
   act_e          act;

   rr_next_sel #(.N(N)) u_rr_next_sel (
      .en     (en),
      .ptr    (ptr),
      .nxt    (ptr_next),
      .any_en (any_en)
   );

   assign free     = !valid || ready;
   assign at_cap   = (cnt == CNT_LAST);
   assign mode_chg = (mode != mode_q);
   assign sel_ok   = (int'(s) < N) && en[s];
   assign d_sel    = d_in[int'(s) * W +: W];
   assign d_ptr    = d_in[int'(ptr) * W +: W];

   always_comb begin
      act = ACT_COUNT;
      if (mode == MODE_MANUAL)  act = ACT_MANUAL;
      else if (mode_chg)        act = ACT_RESTART;
      else if (!at_cap)         act = ACT_COUNT;
      else if (!any_en)         act = ACT_IDLE;
      else if (!en[ptr])        act = ACT_SKIP;
      else if (!free)           act = ACT_STALL;
      else                      act = ACT_CAPTURE;
   end

   // mode_q resets to scan so a part held in scan through reset does not lose
   // its first dwell period to a spurious mode-change restart.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y      <= '0;
         ch     <= '0;
         valid  <= 1'b0;
         ptr    <= '0;
         cnt    <= '0;
         mode_q <= MODE_SCAN;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         mode_q <= mode;
         unique case (act)
            ACT_MANUAL: begin
               cnt <= '0;
               if (free) begin
                  if (sel_ok) begin
                     y     <= d_sel;
                     ch    <= s;
                     valid <= 1'b1;
                  end else begin
                     valid <= 1'b0;
                  end
               end
            end
            ACT_RESTART: begin
               cnt <= '0;
               if (free) valid <= 1'b0;
            end
            ACT_COUNT: begin
               cnt <= cnt + 1'b1;
               if (free) valid <= 1'b0;
            end
            ACT_IDLE: begin
               if (free) valid <= 1'b0;
            end
            ACT_SKIP: begin
               ptr <= ptr_next;
               cnt <= '0;
               if (free) valid <= 1'b0;
            end
            ACT_STALL: begin
               // Held at the capture point until the consumer takes the pending sample.
            end
            ACT_CAPTURE: begin
               y     <= d_ptr;
               ch    <= ptr;
               valid <= 1'b1;
               cnt   <= '0;
               ptr   <= ptr_next;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nchan_seq_mux.sv
// Directed self-checking bench for nchan_seq_mux (N=4, W=4, DWELL=4).
// Channels 0..3 carry A,B,C,D; expectations are hand-computed per step.
module tb_nchan_seq_mux;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] d_in;
   logic [1:0]  s;
   logic        mode;
   logic [3:0]  en;
   logic        ready;
   logic [3:0]  y;
   logic [1:0]  ch;
   logic        valid;

   int n_tests = 0;
   int n_fail  = 0;

   nchan_seq_mux #(.N(4), .W(4), .DWELL(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .d_in  (d_in),
      .s     (s),
      .mode  (mode),
      .en    (en),
      .ready (ready),
      .y     (y),
      .ch    (ch),
      .valid (valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [3:0] ey, input logic [1:0] ech,
                            input logic ev);
      check({tag, ".y"},     32'(y),     32'(ey));
      check({tag, ".ch"},    32'(ch),    32'(ech));
      check({tag, ".valid"}, 32'(valid), 32'(ev));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   logic [3:0] tab [4] = '{4'hA, 4'hB, 4'hC, 4'hD};

   initial begin
      rst_n = 1'b0;
      mode  = 1'b0;
      s     = 2'd0;
      en    = 4'hF;
      ready = 1'b1;
      d_in  = {4'hD, 4'hC, 4'hB, 4'hA};
      #3;
      check_out("reset", 4'h0, 2'd0, 1'b0);
      rst_n = 1'b1;

      // Manual sweep.
      for (int k = 0; k < 4; k++) begin
         s = 2'(k);
         step();
         check_out($sformatf("sweep%0d", k), tab[k], 2'(k), 1'b1);
      end

      // Backpressure: sample B must survive while s moves to 3.
      s = 2'd1;
      step();
      check_out("bp_load", 4'hB, 2'd1, 1'b1);
      ready = 1'b0;
      s     = 2'd3;
      for (int k = 0; k < 5; k++) begin
         step();
         check_out($sformatf("bp_hold%0d", k), 4'hB, 2'd1, 1'b1);
      end
      ready = 1'b1;
      step();
      check_out("bp_release", 4'hD, 2'd3, 1'b1);

      // Disabled manual select: VALID drops, Y/CH hold.
      en = 4'hE;
      s  = 2'd0;
      step();
      check_out("man_disabled", 4'hD, 2'd3, 1'b0);

      // Full scan from reset: captures on edges 4,8,12,16,20.
      mode = 1'b1;
      en   = 4'hF;
      do_reset();
      for (int e = 1; e <= 20; e++) begin
         step();
         if (e % 4 == 0)
            check_out($sformatf("scan_e%0d", e), tab[(e/4 - 1) % 4], 2'((e/4 - 1) % 4), 1'b1);
         else
            check($sformatf("scan_idle_e%0d", e), 32'(valid), 32'd0);
      end

      // Masked scan 1010: edge 4 skips channel 0, then 1,3,1,3.
      en = 4'hA;
      do_reset();
      for (int e = 1; e <= 20; e++) begin
         step();
         if (e == 4) check("mask_skip0", 32'(valid), 32'd0);
         if (e >= 8 && e % 4 == 0)
            check_out($sformatf("mask_e%0d", e), (e % 8 == 0) ? 4'hB : 4'hD,
                      (e % 8 == 0) ? 2'd1 : 2'd3, 1'b1);
      end

      // Empty mask: nothing captured, CH holds.
      en = 4'h0;
      repeat (8) step();
      check_out("mask_empty", 4'hD, 2'd3, 1'b0);

      // Single channel 2: skip from frozen ptr=1 to 2, then capture every DWELL.
      en = 4'h4;
      repeat (4) step();
      check("single_wait", 32'(valid), 32'd0);
      step();
      check_out("single_cap0", 4'hC, 2'd2, 1'b1);
      repeat (3) step();
      check("single_gap", 32'(valid), 32'd0);
      step();
      check_out("single_cap1", 4'hC, 2'd2, 1'b1);

      // Reset during a stall.
      en    = 4'hF;
      ready = 1'b0;
      do_reset();
      repeat (4) step();
      check_out("stall_cap", 4'hA, 2'd0, 1'b1);
      repeat (2) step();
      check_out("stall_hold", 4'hA, 2'd0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_out("async_rst", 4'h0, 2'd0, 1'b0);
      rst_n = 1'b1;
      ready = 1'b1;
      repeat (3) step();
      check("post_rst_wait", 32'(valid), 32'd0);
      step();
      check_out("post_rst_cap", 4'hA, 2'd0, 1'b1);

      // Mode switch: manual capture, then scan restarts its dwell from the change edge.
      mode = 1'b0;
      s    = 2'd2;
      step();
      check_out("to_manual", 4'hC, 2'd2, 1'b1);
      mode = 1'b1;
      repeat (4) step();
      check("to_scan_wait", 32'(valid), 32'd0);
      step();
      check_out("to_scan_cap", 4'hB, 2'd1, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
